// File: rtl/sensor_image_roi_crop_if.sv
// sensor_image_roi_crop_if
//   Pixel stream bundle used on both sides of the ROI crop.
//   vsync : H = frame valid, L = frame sync
//   href  : H = line valid
//   de    : H = pixel valid
//   data  : pixel data, DATA_WIDTH bits
//   master modport drives the stream, slave modport receives it.
interface sensor_image_roi_crop_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  vsync;
  logic                  href;
  logic                  de;
  logic [DATA_WIDTH-1:0] data;

  modport master (output vsync, output href, output de, output data);
  modport slave  (input  vsync, input  href, input  de, input  data);
endinterface

// File: rtl/sensor_image_roi_crop.sv
// sensor_image_roi_crop
//   Run-time programmable region-of-interest crop for a vsync/href/de
//   pixel stream, with frame-start-synchronised window updates and
//   measurement of the incoming frame size.
// Ports
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   cfg_enable         1 = crop, 0 = bypass
//   cfg_x_start/y_start/h_size/v_size  requested window
//   cfg_update         strobe: capture cfg_* into the pending set
//   image_in           input stream (slave)
//   image_out          cropped stream, registered, 1 clk latency (master)
//   stat_in_hsize      de count of the last line of the previous frame
//   stat_in_vsize      line count of the previous frame
//   stat_valid         one-cycle pulse when stat_* update
module sensor_image_roi_crop #(
  parameter int PIXEL_DATA_WIDTH = 24,
  parameter int POS_WIDTH        = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_enable,
  input  logic [POS_WIDTH-1:0] cfg_x_start,
  input  logic [POS_WIDTH-1:0] cfg_y_start,
  input  logic [POS_WIDTH-1:0] cfg_h_size,
  input  logic [POS_WIDTH-1:0] cfg_v_size,
  input  logic                 cfg_update,
  sensor_image_roi_crop_if.slave  image_in,
  sensor_image_roi_crop_if.master image_out,
  output logic [POS_WIDTH-1:0] stat_in_hsize,
  output logic [POS_WIDTH-1:0] stat_in_vsize,
  output logic                 stat_valid
);

  localparam logic [POS_WIDTH-1:0] POS_MAX = {POS_WIDTH{1'b1}};
  localparam logic [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [POS_WIDTH-1:0] xs;
    logic [POS_WIDTH-1:0] ys;
    logic [POS_WIDTH-1:0] hs;
    logic [POS_WIDTH-1:0] vs;
  } win_t;

  state_t                      state_r, state_nx_s;
  win_t                        cfg_in_s, pend_r, act_r;
  logic                        pend_flag_r;
  logic                        vsync_d_r, href_d_r;
  logic                        vs_rise_s, vs_fall_s, href_fall_s;
  logic                        active_s, vsync_ok_s, load_s, stat_take_s;
  logic [POS_WIDTH-1:0]        xpos_r, ypos_r, line_de_r;
  logic [POS_WIDTH:0]          x_end_s, y_end_s;
  logic                        x_in_s, y_in_s, de_s;
  logic [POS_WIDTH-1:0]        vsize_nx_s, hsize_nx_s;
  logic                        out_vsync_r, out_href_r, out_de_r;
  logic [PIXEL_DATA_WIDTH-1:0] out_data_r;
  logic [POS_WIDTH-1:0]        stat_h_r, stat_v_r;
  logic                        stat_valid_r;

  assign cfg_in_s.en = cfg_enable;
  assign cfg_in_s.xs = cfg_x_start;
  assign cfg_in_s.ys = cfg_y_start;
  assign cfg_in_s.hs = cfg_h_size;
  assign cfg_in_s.vs = cfg_v_size;

  assign vs_rise_s   = image_in.vsync & ~vsync_d_r;
  assign vs_fall_s   = ~image_in.vsync & vsync_d_r;
  assign href_fall_s = ~image_in.href & href_d_r;

  // Input history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
      href_d_r  <= 1'b0;
    end else begin
      vsync_d_r <= image_in.vsync;
      href_d_r  <= image_in.href;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= WAIT_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic; WAIT_IDLE drops a frame already running at reset release.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      WAIT_IDLE: if (!image_in.vsync) state_nx_s = IDLE;   else state_nx_s = WAIT_IDLE;
      IDLE:      if (vs_rise_s)       state_nx_s = ACTIVE; else state_nx_s = IDLE;
      ACTIVE:    if (vs_fall_s)       state_nx_s = IDLE;   else state_nx_s = ACTIVE;
      default:   state_nx_s = WAIT_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    active_s    = 1'b0;
    vsync_ok_s  = 1'b0;
    load_s      = 1'b0;
    stat_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        vsync_ok_s = 1'b1;
        load_s     = vs_rise_s;
      end
      ACTIVE: begin
        active_s    = 1'b1;
        vsync_ok_s  = 1'b1;
        stat_take_s = vs_fall_s;
      end
      default: begin
        active_s    = 1'b0;
        vsync_ok_s  = 1'b0;
      end
    endcase
  end

  // Pending/active window sets; a strobe coincident with frame start goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= '0;
      act_r       <= '0;
      pend_flag_r <= 1'b0;
    end else begin
      if (cfg_update) pend_r <= cfg_in_s;
      if (load_s) begin
        pend_flag_r <= 1'b0;
        if (cfg_update)       act_r <= cfg_in_s;
        else if (pend_flag_r) act_r <= pend_r;
      end else if (cfg_update) begin
        pend_flag_r <= 1'b1;
      end
    end
  end

  // Position counters (saturating); line_de_r keeps the last completed line length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_r    <= '0;
      ypos_r    <= '0;
      line_de_r <= '0;
    end else begin
      if (!image_in.href)                      xpos_r <= '0;
      else if (image_in.de && xpos_r != POS_MAX) xpos_r <= xpos_r + POS_ONE;
      if (!active_s)                           ypos_r <= '0;
      else if (href_fall_s && ypos_r != POS_MAX) ypos_r <= ypos_r + POS_ONE;
      if (!active_s)        line_de_r <= '0;
      else if (href_fall_s) line_de_r <= xpos_r;
    end
  end

  // Window test on pre-increment counters, one bit wider so start+size cannot wrap.
  assign x_end_s = {1'b0, act_r.xs} + {1'b0, act_r.hs};
  assign y_end_s = {1'b0, act_r.ys} + {1'b0, act_r.vs};

  always_comb begin
    if (act_r.en) begin
      x_in_s = (xpos_r >= act_r.xs) && ({1'b0, xpos_r} < x_end_s);
      y_in_s = (ypos_r >= act_r.ys) && ({1'b0, ypos_r} < y_end_s);
    end else begin
      x_in_s = 1'b1;
      y_in_s = 1'b1;
    end
  end

  assign de_s = image_in.de & active_s & y_in_s & x_in_s;

  // Frame size at vsync fall: a line still open (or just closing) has not been counted yet.
  always_comb begin
    if ((href_d_r || image_in.href) && ypos_r != POS_MAX) vsize_nx_s = ypos_r + POS_ONE;
    else                                                  vsize_nx_s = ypos_r;
    if (href_fall_s) hsize_nx_s = xpos_r;
    else             hsize_nx_s = line_de_r;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vsync_r  <= 1'b0;
      out_href_r   <= 1'b0;
      out_de_r     <= 1'b0;
      out_data_r   <= '0;
      stat_h_r     <= '0;
      stat_v_r     <= '0;
      stat_valid_r <= 1'b0;
    end else begin
      out_vsync_r  <= image_in.vsync & vsync_ok_s;
      out_href_r   <= image_in.href & active_s & y_in_s;
      out_de_r     <= de_s;
      out_data_r   <= de_s ? image_in.data : '0;
      stat_valid_r <= stat_take_s;
      if (stat_take_s) begin
        stat_h_r <= hsize_nx_s;
        stat_v_r <= vsize_nx_s;
      end
    end
  end

  assign image_out.vsync = out_vsync_r;
  assign image_out.href  = out_href_r;
  assign image_out.de    = out_de_r;
  assign image_out.data  = out_data_r;
  assign stat_in_hsize   = stat_h_r;
  assign stat_in_vsize   = stat_v_r;
  assign stat_valid      = stat_valid_r;

endmodule

// File: tb/tb_sensor_image_roi_crop.sv
// tb_sensor_image_roi_crop
//   Directed bench for sensor_image_roi_crop: 16x8 frames with pixel data
//   {y, x}, per-frame counters of output de/lines/vsync rises, window and
//   bypass consistency, latency and statistics against hand-computed values.
module tb_sensor_image_roi_crop;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable, cfg_update;
  logic [11:0] cfg_x_start, cfg_y_start, cfg_h_size, cfg_v_size;
  logic [11:0] stat_h, stat_v;
  logic        stat_valid;

  always #5 clk = ~clk;

  sensor_image_roi_crop_if #(.DATA_WIDTH(24)) img_in ();
  sensor_image_roi_crop_if #(.DATA_WIDTH(24)) img_out ();

  sensor_image_roi_crop #(.PIXEL_DATA_WIDTH(24), .POS_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_x_start(cfg_x_start), .cfg_y_start(cfg_y_start),
    .cfg_h_size(cfg_h_size), .cfg_v_size(cfg_v_size), .cfg_update(cfg_update),
    .image_in(img_in), .image_out(img_out),
    .stat_in_hsize(stat_h), .stat_in_vsize(stat_v), .stat_valid(stat_valid)
  );

  int total = 0;
  int bad   = 0;

  // monitor state
  int cyc = 0, in_cyc = -100, first_cyc = -1;
  int de_cnt, line_cnt, vs_rise, win_err, byp_err, stat_cnt;
  logic [23:0] first_data;
  logic [11:0] last_sh, last_sv;
  logic prev_oh, prev_ov;
  bit bypass_on = 1'b0;
  int ex0, ew, ey0, eh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    de_cnt = 0; line_cnt = 0; vs_rise = 0; win_err = 0; byp_err = 0; stat_cnt = 0;
    first_cyc = -1; first_data = 24'h0; prev_oh = 1'b0; prev_ov = 1'b0;
  endtask

  task automatic set_win(input int x0, input int w, input int y0, input int h);
    ex0 = x0; ew = w; ey0 = y0; eh = h;
  endtask

  task automatic set_cfg(input bit en, input int xs, input int ys, input int hs, input int vs);
    cfg_enable = en; cfg_x_start = 12'(xs); cfg_y_start = 12'(ys);
    cfg_h_size = 12'(hs); cfg_v_size = 12'(vs);
  endtask

  // One clock; outputs sampled 1 time unit after the edge reflect the inputs just applied.
  task automatic tick();
    logic        p_de;
    logic [23:0] p_data;
    int ox, oy;
    p_de = img_in.de; p_data = img_in.data;
    @(posedge clk); #1;
    cyc++;
    if (img_out.de) begin
      de_cnt++;
      ox = int'(img_out.data[11:0]);
      oy = int'(img_out.data[23:12]);
      if (first_cyc < 0) begin first_cyc = cyc; first_data = img_out.data; end
      if (ox < ex0 || ox >= ex0 + ew || oy < ey0 || oy >= ey0 + eh) win_err++;
    end
    if (img_out.href && !prev_oh) line_cnt++;
    prev_oh = img_out.href;
    if (img_out.vsync && !prev_ov) vs_rise++;
    prev_ov = img_out.vsync;
    if (bypass_on && (img_out.de !== p_de || img_out.data !== (p_de ? p_data : 24'h0))) byp_err++;
    if (stat_valid) begin stat_cnt++; last_sh = stat_h; last_sv = stat_v; end
  endtask

  task automatic pulse_update();
    cfg_update = 1'b1; tick(); cfg_update = 1'b0;
  endtask

  task automatic frame_begin(input bit upd_at_rise);
    img_in.vsync = 1'b0; repeat (3) tick();
    img_in.vsync = 1'b1;
    if (upd_at_rise) cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    tick();
  endtask

  task automatic send_pix(input int y, input int x);
    img_in.de = 1'b1; img_in.data = {12'(y), 12'(x)};
    if (y == 2 && x == 4) in_cyc = cyc;
    tick();
  endtask

  task automatic line_gap();
    img_in.href = 1'b0; img_in.de = 1'b0; img_in.data = 24'h0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int y);
    img_in.href = 1'b1;
    for (int x = 0; x < 16; x++) send_pix(y, x);
    line_gap();
  endtask

  task automatic frame_end();
    tick();
    img_in.vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic full_frame(input bit upd_at_rise);
    frame_begin(upd_at_rise);
    for (int y = 0; y < 8; y++) send_line(y);
    frame_end();
  endtask

  initial begin
    rst_n = 1'b0; cfg_update = 1'b0; set_cfg(1'b0, 0, 0, 0, 0);
    img_in.vsync = 1'b0; img_in.href = 1'b0; img_in.de = 1'b0; img_in.data = 24'h0;
    set_win(0, 16, 0, 8); clr_mon();
    repeat (3) tick();
    check("rst_vsync", img_out.vsync, 1'b0);
    check("rst_href", img_out.href, 1'b0);
    check("rst_de", img_out.de, 1'b0);
    check("rst_data", img_out.data, 24'h0);
    check("rst_stat_h", stat_h, 12'h0);
    check("rst_stat_v", stat_v, 12'h0);
    check("rst_stat_valid", stat_valid, 1'b0);
    rst_n = 1'b1; tick();

    // crop x4 y2 8x4
    set_cfg(1'b1, 4, 2, 8, 4); pulse_update(); set_win(4, 8, 2, 4); clr_mon();
    full_frame(1'b0);
    check("crop_de", de_cnt, 32);
    check("crop_lines", line_cnt, 4);
    check("crop_first", first_data, 24'h002004);
    check("crop_latency", first_cyc - in_cyc, 1);
    check("crop_win", win_err, 0);
    check("crop_stat_cnt", stat_cnt, 1);
    check("crop_stat_h", last_sh, 12'd16);
    check("crop_stat_v", last_sv, 12'd8);
    check("crop_vs_rise", vs_rise, 1);

    // bypass
    set_cfg(1'b0, 4, 2, 8, 4); pulse_update(); set_win(0, 16, 0, 8); clr_mon();
    bypass_on = 1'b1;
    full_frame(1'b0);
    bypass_on = 1'b0;
    check("byp_de", de_cnt, 128);
    check("byp_lines", line_cnt, 8);
    check("byp_match", byp_err, 0);
    check("byp_first", first_data, 24'h000000);

    // mid-frame update: current frame keeps x4, next starts at x0
    set_cfg(1'b1, 4, 2, 8, 4); pulse_update(); set_win(4, 8, 2, 4); clr_mon();
    cfg_x_start = 12'd0;
    frame_begin(1'b0);
    for (int y = 0; y < 8; y++) begin
      if (y == 3) pulse_update();
      send_line(y);
    end
    frame_end();
    check("mid_cur_de", de_cnt, 32);
    check("mid_cur_first", first_data, 24'h002004);
    check("mid_cur_win", win_err, 0);
    set_win(0, 8, 2, 4); clr_mon();
    full_frame(1'b0);
    check("mid_next_de", de_cnt, 32);
    check("mid_next_first", first_data, 24'h002000);
    check("mid_next_win", win_err, 0);

    // window past the right edge: truncated to 4 pixels
    set_cfg(1'b1, 12, 2, 8, 4); pulse_update(); set_win(12, 8, 2, 4); clr_mon();
    full_frame(1'b0);
    check("trunc_de", de_cnt, 16);
    check("trunc_lines", line_cnt, 4);
    check("trunc_first", first_data, 24'h00200c);
    check("trunc_win", win_err, 0);

    // zero height: no de, vsync still passes
    set_cfg(1'b1, 12, 2, 8, 0); pulse_update(); clr_mon();
    full_frame(1'b0);
    check("v0_de", de_cnt, 0);
    check("v0_lines", line_cnt, 0);
    check("v0_vs_rise", vs_rise, 1);
    check("v0_stat_v", last_sv, 12'd8);

    // update in the same cycle as vsync rise
    set_cfg(1'b1, 1, 0, 2, 1); set_win(1, 2, 0, 1); clr_mon();
    full_frame(1'b1);
    check("rise_de", de_cnt, 2);
    check("rise_lines", line_cnt, 1);
    check("rise_first", first_data, 24'h000001);

    // reset mid-frame, released while vsync high
    set_cfg(1'b0, 0, 0, 0, 0); clr_mon();
    frame_begin(1'b0);
    send_line(0);
    img_in.href = 1'b1;
    for (int x = 0; x < 5; x++) send_pix(1, x);
    check("mid_rst_pre_vsync", img_out.vsync, 1'b1);
    rst_n = 1'b0; #1;
    check("mid_rst_vsync", img_out.vsync, 1'b0);
    check("mid_rst_href", img_out.href, 1'b0);
    check("mid_rst_de", img_out.de, 1'b0);
    check("mid_rst_data", img_out.data, 24'h0);
    tick();
    rst_n = 1'b1; clr_mon(); set_win(0, 16, 0, 8);
    for (int x = 5; x < 16; x++) send_pix(1, x);
    line_gap();
    for (int y = 2; y < 8; y++) send_line(y);
    frame_end();
    check("drop_vs_rise", vs_rise, 0);
    check("drop_de", de_cnt, 0);
    check("drop_lines", line_cnt, 0);
    check("drop_stat_cnt", stat_cnt, 0);
    clr_mon();
    full_frame(1'b0);
    check("after_rst_de", de_cnt, 128);
    check("after_rst_vs_rise", vs_rise, 1);
    check("after_rst_stat_cnt", stat_cnt, 1);
    check("after_rst_stat_h", last_sh, 12'd16);
    check("after_rst_stat_v", last_sv, 12'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
